// File: rtl/hci_mem_mux_static_ctrl.sv
// Round-robin ownership controller for the static TCDM mux: one requester owns the port at a time,
// and sel_o is held until every read counted on the mux output has returned its r_valid.
module hci_mem_mux_static_ctrl #(
  parameter  int unsigned NB_CHAN         = 2,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned SW              = $clog2(NB_CHAN-1)+1,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [NB_CHAN-1:0] claim_i,
  input  logic               mon_req_i,
  input  logic               mon_gnt_i,
  input  logic               mon_wen_i,
  input  logic               mon_r_valid_i,
  output logic [SW-1:0]      sel_o,
  output logic [NB_CHAN-1:0] grant_o,
  output logic               busy_o,
  output logic               stall_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          rd_cnt;
  logic          pick_vld;
  logic [SW-1:0] pick_idx;
  int            cand;

  // Outstanding-read tracking; a read and a response in the same cycle cancel out.
  always_comb begin
    rd_cnt = mon_req_i & mon_gnt_i & mon_wen_i;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (rd_cnt && !mon_r_valid_i) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + CW'(1);
    end else if (!rd_cnt && mon_r_valid_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  // First claiming channel after the previous owner, wrapping modulo NB_CHAN.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = 1; i <= int'(NB_CHAN); i++) begin
      cand = (int'(last_q) + i) % int'(NB_CHAN);
      if (!pick_vld && claim_i[cand[SW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick_idx;
          last_d  = pick_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!claim_i[sel_q]) state_d = (cnt_d == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SW'(NB_CHAN-1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    grant_o = '0;
    if (state_q == OWN) grant_o[sel_q] = 1'b1;
  end

  assign sel_o   = sel_q;
  assign busy_o  = (state_q != IDLE);
  assign stall_o = (cnt_q == CNT_MAX);
  assign err_o   = err_q;

endmodule

// File: tb/tb_hci_mem_mux_static_ctrl.sv
// Randomized bench for hci_mem_mux_static_ctrl against a cycle-level reference model of ownership rules.
module tb_hci_mem_mux_static_ctrl;

  localparam int NB_CHAN = 3;
  localparam int MAX_OUT = 2;
  localparam int SW      = $clog2(NB_CHAN-1)+1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, clear;
  logic [NB_CHAN-1:0] claim;
  logic               req, gnt, wen, rv;
  logic [SW-1:0]      sel;
  logic [NB_CHAN-1:0] grant;
  logic               busy, stall, err;

  hci_mem_mux_static_ctrl #(
    .NB_CHAN         (NB_CHAN),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .claim_i       (claim),
    .mon_req_i     (req),
    .mon_gnt_i     (gnt),
    .mon_wen_i     (wen),
    .mon_r_valid_i (rv),
    .sel_o         (sel),
    .grant_o       (grant),
    .busy_o        (busy),
    .stall_o       (stall),
    .err_o         (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the port, whether the port is still held, reads in flight.
  int m_sel, m_last, m_cnt;
  bit m_busy, m_owned, m_err;
  int rd_pct, rv_pct, clm_pct;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel   = 0;
    m_last  = NB_CHAN - 1;
    m_cnt   = 0;
    m_busy  = 1'b0;
    m_owned = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    int n;
    if (!rst_n || clear) begin
      model_reset();
    end else begin
      n = m_cnt + ((req && gnt && wen) ? 1 : 0) - (rv ? 1 : 0);
      if (n > MAX_OUT) begin m_err = 1'b1; n = MAX_OUT; end
      if (n < 0)       begin m_err = 1'b1; n = 0;       end
      if (!m_busy) begin
        for (int k = 1; k <= NB_CHAN; k++) begin
          int c;
          c = (m_last + k) % NB_CHAN;
          if (!m_busy && claim[c]) begin
            m_sel   = c;
            m_last  = c;
            m_busy  = 1'b1;
            m_owned = 1'b1;
          end
        end
      end else if (m_owned) begin
        if (!claim[m_sel]) begin
          m_owned = 1'b0;
          m_busy  = (n != 0);
        end
      end else if (n == 0) begin
        m_busy = 1'b0;
      end
      m_cnt = n;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sel",   32'(sel),   32'(m_sel));
    chk("grant", 32'(grant), m_owned ? (32'd1 << m_sel) : 32'd0);
    chk("busy",  32'(busy),  32'(m_busy));
    chk("stall", 32'(stall), 32'(m_cnt == MAX_OUT));
    chk("err",   32'(err),   32'(m_err));
  endtask

  task automatic drive_rand();
    for (int c = 0; c < NB_CHAN; c++)
      if (int'($urandom_range(99)) < clm_pct) claim[c] = ~claim[c];
    req   = (int'($urandom_range(99)) < rd_pct);
    gnt   = 1'($urandom_range(1));
    wen   = ($urandom_range(3) != 0);
    rv    = (m_cnt > 0) ? (int'($urandom_range(99)) < rv_pct) : ($urandom_range(99) < 2);
    clear = ($urandom_range(199) == 0);
    rst_n = ($urandom_range(499) != 0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; clear = 1'b0; claim = '0;
    req = 1'b0; gnt = 1'b0; wen = 1'b0; rv = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      claim = NB_CHAN'($urandom);
      req   = 1'($urandom); gnt = 1'($urandom);
      wen   = 1'($urandom); rv  = 1'($urandom);
      clear = 1'($urandom);
      cycle();
    end

    // Released with nobody claiming: must stay idle.
    rst_n = 1'b1; clear = 1'b0; claim = '0;
    req = 1'b0; gnt = 1'b0; wen = 1'b0; rv = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    for (int p = 0; p < 20; p++) begin
      rd_pct  = int'($urandom_range(5, 45));
      rv_pct  = int'($urandom_range(10, 70));
      clm_pct = int'($urandom_range(2, 30));
      clear   = 1'b1;
      rst_n   = 1'b1;
      cycle();
      for (int i = 0; i < 200; i++) begin
        drive_rand();
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hci_mem_mux_static_ctrl.md
# hci_mem_mux_static_ctrl

Ownership controller for the static TCDM multiplexer. It arbitrates exclusive, round-robin ownership of the shared memory port among `NB_CHAN` requesters and drives the static mux select. It tracks outstanding reads on the mux output and moves `sel_o` only after every response has returned, so no `r_valid` is routed to the wrong channel. It sits next to the static mux in the HWPE/cluster interconnect.

## Interface
- `NB_CHAN`, default 2: number of requesters, 2..16.
- `MAX_OUTSTANDING`, default 4: read-tracking capacity, ≥1. Counter width is `CW = $clog2(MAX_OUTSTANDING+1)`.
- `SW`, derived, not overridable: `$clog2(NB_CHAN-1)+1`. Matches the mux `sel_i` width.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `clear_i`  in  1  synchronous soft clear, same effect as reset.
- `claim_i`  in  NB_CHAN  level per channel; channel wants or keeps ownership.
- `mon_req_i`, `mon_gnt_i`, `mon_wen_i`, `mon_r_valid_i`  in  1 each  monitor taps on the mux output side. `wen=1` means read.
- `sel_o`  out  SW  select to the static mux.
- `grant_o`  out  NB_CHAN  one-hot; the owner may issue requests.
- `busy_o`  out  1  state ≠ IDLE.
- `stall_o`  out  1  outstanding counter is full; the owner must not issue reads.
- `err_o`  out  1  sticky protocol error.

## Operation
- States:
  - IDLE: no owner.
  - OWN: `grant_o[sel_o]=1`.
  - DRAIN: `grant_o=0`, `sel_o` held.
- Counter `cnt`:
  - next = `cnt` + (`mon_req_i & mon_gnt_i & mon_wen_i`) − `mon_r_valid_i`.
  - Increment and decrement in the same cycle leave it unchanged.
  - Writes are not counted.
- IDLE:
  - If any `claim_i` is set, pick the first set bit scanning from `last+1` modulo NB_CHAN.
  - Load `sel_o`, set `last` to the picked index, go to OWN.
  - Otherwise stay; `sel_o` keeps its last value.
- OWN, when `claim_i[sel_o]=0`:
  - next `cnt` = 0 → IDLE.
  - otherwise → DRAIN.
  - `claim_i` of other channels has no effect in OWN.
- DRAIN: next `cnt` = 0 → IDLE. Owner re-asserting claim in DRAIN has no effect; it re-arbitrates in IDLE.
- `stall_o` = (`cnt == MAX_OUTSTANDING`), combinational from the register.
- Overflow: a counted read at `cnt == MAX_OUTSTANDING` without `r_valid` sets `err_o`; `cnt` saturates.
- Underflow: `mon_r_valid_i` at `cnt==0` without a counted read sets `err_o`; `cnt` stays 0.
- Read-grant and `r_valid` in the same cycle at `cnt==0`: net 0, no error.
- `err_o` clears only on reset or `clear_i`.
- `rst_ni=0` or `clear_i=1` (either, next edge):
  - state IDLE, `cnt=0`, `sel_o=0`, `last=NB_CHAN-1`, `err_o=0`. This applies even mid-DRAIN.
  - Late `r_valid` arriving after the clear is treated as underflow.
- Reset values of outputs: `sel_o=0`, `grant_o=0`, `busy_o=0`, `stall_o=0`, `err_o=0`.

## Timing
- All outputs are registered state or decoded directly from state; no input-to-output combinational path.
- Claim to grant:
  - Claim sampled in IDLE at edge t.
  - `grant_o`/`sel_o` valid from t+1.
- Release:
  - Claim low in cycle t with no reads pending: IDLE at t+1; next owner granted at t+2. There is a minimum 1-cycle bubble between owners.
  - With reads pending: DRAIN until the cycle of the last `r_valid`, IDLE the following cycle.
- `sel_o` never changes in OWN or DRAIN. It changes only on the IDLE→OWN edge.
- A read granted in the release cycle is counted. A write granted in the release cycle does not delay release.

## Test plan
- Reset:
  - Hold `rst_ni=0` 3 cycles with random inputs → all outputs 0.
  - Release with `claim_i=2'b00` → `busy_o=0` indefinitely.
- Single claim:
  - `claim_i=2'b10` at cycle 0 → cycle 1 `sel_o=1`, `grant_o=2'b10`, `busy_o=1`.
  - Drop claim at cycle 4, no reads → IDLE at 5, `grant_o=0`, `sel_o` stays 1.
- Round-robin:
  - `claim_i=2'b11` after reset → ch0 owns first.
  - ch0 drops claim, ch1 holds → `grant_o=2'b10` exactly 2 cycles after ch0's release.
  - ch1 releases, both claim → ch0 next.
- Drain:
  - ch0 owns; read granted in cycle 3, claim dropped in cycle 3 → DRAIN, `sel_o=0`, `grant_o=0`.
  - `r_valid` in cycle 7 → IDLE cycle 8, ch1 granted cycle 9.
- Stall, with `MAX_OUTSTANDING=2`:
  - Two read grants, no `r_valid` → `stall_o=1`.
  - Read grant and `r_valid` in the same cycle → `cnt` stays 2, `err_o=0`.
  - One more read, no `r_valid` → `err_o=1`.
- Errors and clear:
  - `r_valid` with `cnt=0` → `err_o=1`, persists 10 cycles.
  - `clear_i` pulse mid-DRAIN with `cnt=1` → next cycle IDLE, `err_o=0`, `sel_o=0`, `cnt=0`.
